ahb_lite_slave_mux: RTL and testbench
=====================================

Name: ahb_lite_slave_mux

Overview:
- Data-phase response multiplexer for the AHB-Lite matrix. It sits directly downstream of the address decoder and consumes its eight HSEL outputs.
- Registers the port selection during the address phase. During the following data phase it routes the chosen slave's HRDATA, HREADYOUT and HRESP back to the Cortex-M0 master.
- Contains an integrated default slave. Any active transfer that no enabled port claims receives a two-cycle ERROR response.

Parameters:
PORT_EN, 8'hFF, per-port enable mask; bit n=0 makes Pn_HSEL ignored, so the address is treated as unmapped.

Ports:
HCLK  in  1  bus clock.
HRESETn  in  1  asynchronous active-low reset.
HREADY  in  1  bus HREADY fed back from master side; high = address phase sampled this cycle.
HTRANS  in  2  master transfer type; bit1=1 means NONSEQ/SEQ.
Pn_HSEL  in  1  decoder select for port n, n=0..7 (8 ports).
Pn_HREADYOUT  in  1  ready from slave n, n=0..7.
Pn_HRESP  in  1  response from slave n, n=0..7 (1=ERROR).
Pn_HRDATA  in  32  read data from slave n, n=0..7.
HREADYOUT  out  1  muxed ready to master.
HRESP  out  1  muxed response to master.
HRDATA  out  32  muxed read data to master.

Behaviour:
- Reset (HRESETn=0, async):
  - sel_q=8'h00, default-slave FSM=IDLE.
  - Outputs: HREADYOUT=1, HRESP=0, HRDATA=32'h0.
  - Reset asserted mid-transfer aborts immediately to these values. No pending error survives reset.
- Effective select: sel_n = Pn_HSEL & PORT_EN[n].
  - If more than one bit is set, the lowest index wins; the one-hot is forced before registering.
- Address-phase capture: on HCLK rising edge with HREADY=1, sel_q <= one-hot(sel). With HREADY=0, sel_q holds.
  - A slave inserting wait states therefore keeps its selection.
- Data-phase mux, combinational from sel_q:
  - sel_q has bit n set: HREADYOUT=Pn_HREADYOUT, HRESP=Pn_HRESP, HRDATA=Pn_HRDATA.
  - sel_q==0: HRDATA=32'h0. HREADYOUT and HRESP come from the default-slave FSM.
- Default-slave FSM (states IDLE, ERR1, ERR2):
  - unmapped = HREADY & HTRANS[1] & (sel==0).
  - IDLE: HREADYOUT=1, HRESP=0. unmapped -> ERR1, else stay.
  - ERR1: HREADYOUT=0, HRESP=1. Always -> ERR2 on the next cycle.
  - ERR2: HREADYOUT=1, HRESP=1.
    - If HREADY=1, the next address phase is sampled: unmapped -> ERR1, else -> IDLE.
    - If HREADY=0 (external hold), stay in ERR2.
- Unmapped IDLE/BUSY transfers (HTRANS[1]=0) get a zero-wait OKAY: FSM stays IDLE.
- Back-to-back transfers:
  - A mapped transfer following an unmapped one is captured during ERR2 (HREADY=1).
  - The mapped slave drives the data phase from the next cycle.
- Latency: no added wait states for mapped ports. Output is purely combinational from sel_q and slave responses.
- Widths: all data paths 32 bits; no arithmetic.

Test Plan:
1. Reset release, HTRANS=IDLE, all HSEL=0 -> HREADYOUT=1, HRESP=0, HRDATA=0 every cycle.
2. NONSEQ with P1_HSEL=1; next cycle P1_HRDATA=32'hDEADBEEF, P1_HREADYOUT=0 for 2 cycles then 1 -> HRDATA=DEADBEEF, HREADYOUT low 2 cycles; sel_q unchanged while stalled.
3. NONSEQ with all HSEL=0 -> next cycle HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1, then IDLE/OKAY.
4. Two consecutive unmapped NONSEQs, then NONSEQ to P4 (P4_HRDATA=32'h12345678) -> ERR1, ERR2, ERR1, ERR2, then OKAY with HRDATA=12345678.
5. PORT_EN=8'hFE, NONSEQ with P0_HSEL=1 -> two-cycle ERROR; P0_HRDATA is never routed.
6. P2_HSEL and P5_HSEL both high -> port 2 is routed; HRESETn pulled low during ERR1 -> outputs immediately 1/0/0 and FSM=IDLE.

Source files
------------

// File: rtl/ahb_lite_slave_mux.sv
// AHB-Lite data-phase response multiplexer for eight slave ports.
// It registers the address-phase selection and includes a default slave that returns a two-cycle ERROR.
module ahb_lite_slave_mux #(
    parameter logic [7:0] PORT_EN = 8'hFF
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HREADY,
    input  logic [1:0]  HTRANS,
    input  logic        P0_HSEL,
    input  logic        P1_HSEL,
    input  logic        P2_HSEL,
    input  logic        P3_HSEL,
    input  logic        P4_HSEL,
    input  logic        P5_HSEL,
    input  logic        P6_HSEL,
    input  logic        P7_HSEL,
    input  logic        P0_HREADYOUT,
    input  logic        P1_HREADYOUT,
    input  logic        P2_HREADYOUT,
    input  logic        P3_HREADYOUT,
    input  logic        P4_HREADYOUT,
    input  logic        P5_HREADYOUT,
    input  logic        P6_HREADYOUT,
    input  logic        P7_HREADYOUT,
    input  logic        P0_HRESP,
    input  logic        P1_HRESP,
    input  logic        P2_HRESP,
    input  logic        P3_HRESP,
    input  logic        P4_HRESP,
    input  logic        P5_HRESP,
    input  logic        P6_HRESP,
    input  logic        P7_HRESP,
    input  logic [31:0] P0_HRDATA,
    input  logic [31:0] P1_HRDATA,
    input  logic [31:0] P2_HRDATA,
    input  logic [31:0] P3_HRDATA,
    input  logic [31:0] P4_HRDATA,
    input  logic [31:0] P5_HRDATA,
    input  logic [31:0] P6_HRDATA,
    input  logic [31:0] P7_HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int unsigned NPORT = 8;
    localparam int unsigned DW    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } dflt_state_e;

    logic [NPORT-1:0]         hsel;
    logic [NPORT-1:0]         rdy;
    logic [NPORT-1:0]         resp;
    logic [NPORT-1:0][DW-1:0] rdata;

    logic [NPORT-1:0] sel_eff_c;
    logic [NPORT-1:0] sel_oh_c;
    logic             unmapped_c;
    logic             dflt_ready_c;
    logic             dflt_resp_c;
    logic [NPORT-1:0] sel_q, sel_d;
    dflt_state_e      state_q, state_d;
    logic             unused_htrans0;

    assign hsel  = {P7_HSEL, P6_HSEL, P5_HSEL, P4_HSEL, P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL};
    assign rdy   = {P7_HREADYOUT, P6_HREADYOUT, P5_HREADYOUT, P4_HREADYOUT,
                    P3_HREADYOUT, P2_HREADYOUT, P1_HREADYOUT, P0_HREADYOUT};
    assign resp  = {P7_HRESP, P6_HRESP, P5_HRESP, P4_HRESP, P3_HRESP, P2_HRESP, P1_HRESP, P0_HRESP};
    assign rdata = {P7_HRDATA, P6_HRDATA, P5_HRDATA, P4_HRDATA,
                    P3_HRDATA, P2_HRDATA, P1_HRDATA, P0_HRDATA};

    // Only HTRANS[1] distinguishes active transfers from IDLE/BUSY.
    assign unused_htrans0 = HTRANS[0];

    // Disabled ports look unmapped; the lowest active index wins when several selects are asserted.
    assign sel_eff_c  = hsel & PORT_EN;
    assign sel_oh_c   = sel_eff_c & (~sel_eff_c + NPORT'(1));
    assign unmapped_c = HREADY & HTRANS[1] & (sel_eff_c == '0);
    assign sel_d      = HREADY ? sel_oh_c : sel_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_q   <= '0;
            state_q <= IDLE;
        end else begin
            sel_q   <= sel_d;
            state_q <= state_d;
        end
    end

    // Default slave: the ERROR response has a wait cycle first, then a ready cycle that the master may hold.
    always_comb begin
        state_d      = state_q;
        dflt_ready_c = 1'b1;
        dflt_resp_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (unmapped_c) state_d = ERR1;
            end
            ERR1: begin
                dflt_ready_c = 1'b0;
                dflt_resp_c  = 1'b1;
                state_d      = ERR2;
            end
            ERR2: begin
                dflt_resp_c = 1'b1;
                if (HREADY) state_d = unmapped_c ? ERR1 : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Data-phase mux: the selected slave drives the response; when no port is selected, the default slave does.
    always_comb begin
        HREADYOUT = dflt_ready_c;
        HRESP     = dflt_resp_c;
        HRDATA    = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (sel_q[i]) begin
                HREADYOUT = rdy[i];
                HRESP     = resp[i];
                HRDATA    = rdata[i];
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_slave_mux.sv
// Bench for ahb_lite_slave_mux: it runs directed scenarios and then randomized traffic.
// Two instances (PORT_EN=FF and FE) are compared against a transfer-level reference model.
module tb_ahb_lite_slave_mux;

    logic        hclk;
    logic        hresetn;
    logic        hready;
    logic [1:0]  htrans;
    logic [7:0]  hsel;
    logic [7:0]  p_rdy;
    logic [7:0]  p_resp;
    logic [31:0] p_data [8];

    logic        a_rdy, a_resp, b_rdy, b_resp;
    logic [31:0] a_data, b_data;

    int checks;
    int failures;

    // Reference state for each instance: the routed port (-1 if none) and the remaining error beats.
    int m_port [2];
    int m_err  [2];
    logic [7:0] m_en [2];

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    ahb_lite_slave_mux #(.PORT_EN(8'hFF)) dut_a (
        .HCLK(hclk), .HRESETn(hresetn), .HREADY(hready), .HTRANS(htrans),
        .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]), .P3_HSEL(hsel[3]),
        .P4_HSEL(hsel[4]), .P5_HSEL(hsel[5]), .P6_HSEL(hsel[6]), .P7_HSEL(hsel[7]),
        .P0_HREADYOUT(p_rdy[0]), .P1_HREADYOUT(p_rdy[1]), .P2_HREADYOUT(p_rdy[2]), .P3_HREADYOUT(p_rdy[3]),
        .P4_HREADYOUT(p_rdy[4]), .P5_HREADYOUT(p_rdy[5]), .P6_HREADYOUT(p_rdy[6]), .P7_HREADYOUT(p_rdy[7]),
        .P0_HRESP(p_resp[0]), .P1_HRESP(p_resp[1]), .P2_HRESP(p_resp[2]), .P3_HRESP(p_resp[3]),
        .P4_HRESP(p_resp[4]), .P5_HRESP(p_resp[5]), .P6_HRESP(p_resp[6]), .P7_HRESP(p_resp[7]),
        .P0_HRDATA(p_data[0]), .P1_HRDATA(p_data[1]), .P2_HRDATA(p_data[2]), .P3_HRDATA(p_data[3]),
        .P4_HRDATA(p_data[4]), .P5_HRDATA(p_data[5]), .P6_HRDATA(p_data[6]), .P7_HRDATA(p_data[7]),
        .HREADYOUT(a_rdy), .HRESP(a_resp), .HRDATA(a_data)
    );

    ahb_lite_slave_mux #(.PORT_EN(8'hFE)) dut_b (
        .HCLK(hclk), .HRESETn(hresetn), .HREADY(hready), .HTRANS(htrans),
        .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]), .P3_HSEL(hsel[3]),
        .P4_HSEL(hsel[4]), .P5_HSEL(hsel[5]), .P6_HSEL(hsel[6]), .P7_HSEL(hsel[7]),
        .P0_HREADYOUT(p_rdy[0]), .P1_HREADYOUT(p_rdy[1]), .P2_HREADYOUT(p_rdy[2]), .P3_HREADYOUT(p_rdy[3]),
        .P4_HREADYOUT(p_rdy[4]), .P5_HREADYOUT(p_rdy[5]), .P6_HREADYOUT(p_rdy[6]), .P7_HREADYOUT(p_rdy[7]),
        .P0_HRESP(p_resp[0]), .P1_HRESP(p_resp[1]), .P2_HRESP(p_resp[2]), .P3_HRESP(p_resp[3]),
        .P4_HRESP(p_resp[4]), .P5_HRESP(p_resp[5]), .P6_HRESP(p_resp[6]), .P7_HRESP(p_resp[7]),
        .P0_HRDATA(p_data[0]), .P1_HRDATA(p_data[1]), .P2_HRDATA(p_data[2]), .P3_HRDATA(p_data[3]),
        .P4_HRDATA(p_data[4]), .P5_HRDATA(p_data[5]), .P6_HRDATA(p_data[6]), .P7_HRDATA(p_data[7]),
        .HREADYOUT(b_rdy), .HRESP(b_resp), .HRDATA(b_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_port(input logic [7:0] sel, input logic [7:0] en);
        logic [7:0] eff;
        eff = sel & en;
        for (int i = 0; i < 8; i++) if (eff[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_port[k] = -1;
            m_err[k]  = 0;
        end
    endtask

    // m_err counts the error beats still owed: 2 means the wait beat is next, 1 means the final beat is next.
    task automatic model_clock();
        int p;
        for (int k = 0; k < 2; k++) begin
            if (!hresetn) begin
                m_port[k] = -1;
                m_err[k]  = 0;
            end else begin
                p = pick_port(hsel, m_en[k]);
                if (m_err[k] == 2) m_err[k] = 1;
                else if (m_err[k] == 0 || hready) m_err[k] = (hready && htrans[1] && p < 0) ? 2 : 0;
                if (hready) m_port[k] = p;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic        er [2];
        logic        es [2];
        logic [31:0] ed [2];
        for (int k = 0; k < 2; k++) begin
            if (m_port[k] >= 0) begin
                er[k] = p_rdy[m_port[k]];
                es[k] = p_resp[m_port[k]];
                ed[k] = p_data[m_port[k]];
            end else begin
                er[k] = (m_err[k] != 2);
                es[k] = (m_err[k] != 0);
                ed[k] = 32'h0;
            end
        end
        check({tag, ".a.rdy"},  32'(a_rdy),  32'(er[0]));
        check({tag, ".a.resp"}, 32'(a_resp), 32'(es[0]));
        check({tag, ".a.data"}, a_data,      ed[0]);
        check({tag, ".b.rdy"},  32'(b_rdy),  32'(er[1]));
        check({tag, ".b.resp"}, 32'(b_resp), 32'(es[1]));
        check({tag, ".b.data"}, b_data,      ed[1]);
    endtask

    task automatic sample(input string tag);
        @(negedge hclk);
        #2;
        compare_all(tag);
    endtask

    task automatic tick();
        @(posedge hclk);
        model_clock();
        #1;
    endtask

    task automatic drive(input logic rd, input logic [1:0] tr, input logic [7:0] hs);
        hready = rd;
        htrans = tr;
        hsel   = hs;
    endtask

    task automatic mid_cycle_reset(input string tag);
        hresetn = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        check({tag, ".rdy"},  32'(a_rdy),  32'h1);
        check({tag, ".resp"}, 32'(a_resp), 32'h0);
        check({tag, ".data"}, a_data,      32'h0);
        tick();
        hresetn = 1'b1;
    endtask

    task automatic randomize_slaves();
        for (int i = 0; i < 8; i++) begin
            p_data[i] = $urandom;
            p_rdy[i]  = ($urandom_range(0, 3) != 0);
            p_resp[i] = ($urandom_range(0, 9) == 0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_en[0]  = 8'hFF;
        m_en[1]  = 8'hFE;
        model_reset();
        hresetn = 1'b0;
        drive(1'b1, 2'b00, 8'h00);
        p_rdy  = 8'hFF;
        p_resp = 8'h00;
        for (int i = 0; i < 8; i++) p_data[i] = 32'h1000_0000 + 32'(i);
        #1;
        compare_all("reset");
        tick();
        tick();
        hresetn = 1'b1;

        // Idle bus after reset release
        for (int c = 0; c < 3; c++) begin
            sample("idle");
            check("idle.rdy", 32'(a_rdy), 32'h1);
            check("idle.data", a_data, 32'h0);
            tick();
        end

        // Mapped read to P1 with two wait states; the stalled pipeline must not change the selection.
        drive(1'b1, 2'b10, 8'h02);
        sample("p1.addr");
        tick();
        p_data[1] = 32'hDEADBEEF;
        p_rdy[1]  = 1'b0;
        drive(1'b0, 2'b10, 8'h10);
        for (int c = 0; c < 2; c++) begin
            sample("p1.wait");
            check("p1.wait.rdy", 32'(a_rdy), 32'h0);
            check("p1.wait.data", a_data, 32'hDEADBEEF);
            tick();
        end
        p_rdy[1] = 1'b1;
        drive(1'b1, 2'b00, 8'h00);
        sample("p1.done");
        check("p1.done.rdy", 32'(a_rdy), 32'h1);
        check("p1.done.data", a_data, 32'hDEADBEEF);
        tick();

        // Single unmapped transfer
        drive(1'b1, 2'b10, 8'h00);
        sample("unm.addr");
        tick();
        drive(1'b0, 2'b00, 8'h00);
        sample("unm.err1");
        check("unm.err1.rdy", 32'(a_rdy), 32'h0);
        check("unm.err1.resp", 32'(a_resp), 32'h1);
        tick();
        drive(1'b1, 2'b00, 8'h00);
        sample("unm.err2");
        check("unm.err2.rdy", 32'(a_rdy), 32'h1);
        check("unm.err2.resp", 32'(a_resp), 32'h1);
        tick();
        sample("unm.okay");
        check("unm.okay.resp", 32'(a_resp), 32'h0);
        tick();

        // Two unmapped transfers back to back, then a mapped read from P4
        drive(1'b1, 2'b10, 8'h00);
        tick();
        for (int r = 0; r < 2; r++) begin
            drive(1'b0, 2'b10, 8'h00);
            sample("b2b.err1");
            check("b2b.err1.rdy", 32'(a_rdy), 32'h0);
            check("b2b.err1.resp", 32'(a_resp), 32'h1);
            tick();
            drive(1'b1, 2'b10, (r == 0) ? 8'h00 : 8'h10);
            sample("b2b.err2");
            check("b2b.err2.rdy", 32'(a_rdy), 32'h1);
            check("b2b.err2.resp", 32'(a_resp), 32'h1);
            tick();
        end
        p_data[4] = 32'h12345678;
        p_rdy[4]  = 1'b1;
        p_resp[4] = 1'b0;
        drive(1'b1, 2'b00, 8'h00);
        sample("b2b.p4");
        check("b2b.p4.resp", 32'(a_resp), 32'h0);
        check("b2b.p4.data", a_data, 32'h12345678);
        tick();

        // P0 is masked in instance b: it returns an ERROR while instance a routes P0.
        p_data[0] = 32'hCAFEF00D;
        p_rdy[0]  = 1'b1;
        drive(1'b1, 2'b10, 8'h01);
        tick();
        drive(1'b0, 2'b00, 8'h00);
        sample("mask.err1");
        check("mask.b.err1.rdy", 32'(b_rdy), 32'h0);
        check("mask.b.err1.resp", 32'(b_resp), 32'h1);
        check("mask.b.err1.data", b_data, 32'h0);
        check("mask.a.data", a_data, 32'hCAFEF00D);
        tick();
        drive(1'b1, 2'b00, 8'h00);
        sample("mask.err2");
        check("mask.b.err2.rdy", 32'(b_rdy), 32'h1);
        check("mask.b.err2.data", b_data, 32'h0);
        tick();

        // With two selects asserted, the lower port wins; a reset during ERR1 takes effect immediately.
        p_data[2] = 32'hAAAA_2222;
        p_data[5] = 32'h5555_5555;
        drive(1'b1, 2'b10, 8'h24);
        tick();
        drive(1'b1, 2'b10, 8'h00);
        sample("prio");
        check("prio.data", a_data, 32'hAAAA_2222);
        tick();
        drive(1'b0, 2'b00, 8'h00);
        sample("rst.err1");
        check("rst.err1.rdy", 32'(a_rdy), 32'h0);
        mid_cycle_reset("rst.mid");
        drive(1'b1, 2'b00, 8'h00);
        sample("rst.after");
        check("rst.after.resp", 32'(a_resp), 32'h0);
        tick();

        // Randomized traffic, including occasional external holds and mid-cycle resets
        for (int c = 0; c < 1500; c++) begin
            int r;
            logic [7:0] hs;
            randomize_slaves();
            r = $urandom_range(0, 9);
            if (r < 3) hs = 8'h00;
            else if (r < 8) hs = 8'(1 << $urandom_range(0, 7));
            else hs = 8'($urandom);
            drive(($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)), hs);
            sample("rand");
            if ($urandom_range(0, 199) == 0) mid_cycle_reset("rand.rst");
            else tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
